odometer_bcd: RTL and testbench

//   Parametrised distance meter: speed-weighted step accumulation on a periodic tick, direct
//   BCD total and trip counters, and a multiplexed digit-scan output. Sits between the car

---
 rtl/odometer_bcd_if.sv | 26 ++
 rtl/odometer_bcd.sv | 134 +++++++++++++
 tb/tb_odometer_bcd.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/odometer_bcd_if.sv
// Control inputs and distance/display outputs of the BCD odometer.
// The master drives mode/sig/trip_clr/disp_sel and the slave (odometer) drives the rest.
interface odometer_bcd_if #(
  parameter int DIGITS = 4
);
  logic [1:0]          mode;
  logic [7:0]          sig;
  logic                trip_clr;
  logic                disp_sel;
  logic [4*DIGITS-1:0] total_bcd;
  logic [4*DIGITS-1:0] trip_bcd;
  logic                active;
  logic                overflow;
  logic [DIGITS-1:0]   scan_an;
  logic [3:0]          scan_nib;

  modport master (
    output mode, sig, trip_clr, disp_sel,
    input  total_bcd, trip_bcd, active, overflow, scan_an, scan_nib
  );

  modport slave (
    input  mode, sig, trip_clr, disp_sel,
    output total_bcd, trip_bcd, active, overflow, scan_an, scan_nib
  );
endinterface

// File: rtl/odometer_bcd.sv
// Speed-weighted distance meter with BCD total/trip counters and a multiplexed digit scan.
// All outputs registered, 1 clk after the tick edge that causes them; no backpressure.
module odometer_bcd #(
  parameter int CLK_DIV    = 200000,
  parameter int UNIT_STEPS = 500,
  parameter int FAST_STEP  = 2,
  parameter int SLOW_STEP  = 1,
  parameter int DIGITS     = 4
) (
  input  logic          clk,
  input  logic          rst,
  odometer_bcd_if.slave bus
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW = $clog2(UNIT_STEPS + FAST_STEP);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NW = 4 * DIGITS;
  localparam logic [AW:0] UNIT_W = (AW+1)'(UNIT_STEPS);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   tick_cnt;
  logic            tick;
  logic [AW-1:0]   acc, acc_n;
  logic [AW:0]     add, sum;
  logic            unit;
  logic [NW-1:0]   total, trip, total_n, trip_n, total_inc, trip_inc, sel_n;
  logic            total_wrap, trip_full;
  logic            ovf, ovf_n, active;
  logic [IW-1:0]   idx, idx_n;
  logic [DIGITS-1:0] scan_an;
  logic [3:0]      scan_nib;
  logic            unused_sig;

  assign unused_sig = ^bus.sig[7:2];
  assign tick = (tick_cnt == CW'(CLK_DIV - 1));

  // Native BCD increment; returns {carry_out_of_top_digit, value}.
  function automatic logic [NW:0] bcd_inc(input logic [NW-1:0] v);
    logic [NW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  assign {total_wrap, total_inc} = bcd_inc(total);
  assign {trip_full,  trip_inc}  = bcd_inc(trip);

  always_comb begin
    state_n = state;
    if (bus.mode == 2'b00) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.mode == 2'b01) state_n = RUN;
        RUN:     if (bus.mode[1])       state_n = PAUSE;
        PAUSE:   if (bus.mode == 2'b01) state_n = RUN;
        default: state_n = IDLE;
      endcase
    end

    add = bus.sig[0] ? (AW+1)'(FAST_STEP) :
          bus.sig[1] ? (AW+1)'(SLOW_STEP) : '0;
    sum  = {1'b0, acc} + add;
    unit = 1'b0;
    acc_n = acc;
    if (state == IDLE) begin
      acc_n = '0;
    end else if (state == RUN && tick) begin
      if (sum >= UNIT_W) begin
        acc_n = AW'(sum - UNIT_W);
        unit  = 1'b1;
      end else begin
        acc_n = sum[AW-1:0];
      end
    end

    total_n = unit ? total_inc : total;
    ovf_n   = ovf | (unit & total_wrap);
    // Trip holds at all-9s; a clear beats a coincident increment.
    if (bus.trip_clr)             trip_n = '0;
    else if (unit && !trip_full)  trip_n = trip_inc;
    else                          trip_n = trip;

    idx_n = idx;
    if (tick) idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    sel_n = bus.disp_sel ? trip_n : total_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      acc      <= '0;
      total    <= '0;
      trip     <= '0;
      ovf      <= 1'b0;
      active   <= 1'b0;
      idx      <= '0;
      scan_an  <= '1;
      scan_nib <= '0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
      acc      <= acc_n;
      total    <= total_n;
      trip     <= trip_n;
      ovf      <= ovf_n;
      active   <= (state_n == RUN);
      idx      <= idx_n;
      scan_an  <= (state_n == IDLE) ? '1 : ~(DIGITS'(1) << idx_n);
      scan_nib <= sel_n[4*idx_n +: 4];
    end
  end

  assign bus.total_bcd = total;
  assign bus.trip_bcd  = trip;
  assign bus.active    = active;
  assign bus.overflow  = ovf;
  assign bus.scan_an   = scan_an;
  assign bus.scan_nib  = scan_nib;
endmodule

// File: tb/tb_odometer_bcd.sv
// Bench for odometer_bcd: directed scenarios plus random traffic, all outputs
// compared every cycle against an integer-arithmetic reference model.
module tb_odometer_bcd;
  localparam int CLK_DIV = 4;
  localparam int UNIT    = 5;
  localparam int FAST    = 2;
  localparam int SLOW    = 1;
  localparam int DIGITS  = 2;
  localparam int MAXV    = 10**DIGITS - 1;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2;

  logic clk = 1'b0;
  logic rst;

  odometer_bcd_if #(.DIGITS(DIGITS)) bus();

  odometer_bcd #(
    .CLK_DIV(CLK_DIV), .UNIT_STEPS(UNIT), .FAST_STEP(FAST),
    .SLOW_STEP(SLOW), .DIGITS(DIGITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain integers for distance, remainder and phase.
  int m_cnt, m_state, m_acc, m_total, m_trip, m_ovf, m_idx;
  bit m_run_tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int step_add(input logic [7:0] s);
    return s[0] ? FAST : (s[1] ? SLOW : 0);
  endfunction

  function automatic bit will_unit();
    return (m_state == S_RUN) && (m_cnt == CLK_DIV - 1) &&
           (m_acc + step_add(bus.sig) >= UNIT);
  endfunction

  task automatic model_edge();
    bit tick, unit;
    m_run_tick = 1'b0;
    if (rst) begin
      m_cnt = 0; m_state = S_IDLE; m_acc = 0; m_total = 0;
      m_trip = 0; m_ovf = 0; m_idx = 0;
      return;
    end
    tick  = (m_cnt == CLK_DIV - 1);
    m_cnt = (m_cnt + 1) % CLK_DIV;
    unit  = 1'b0;
    if (m_state == S_IDLE) begin
      m_acc = 0;
    end else if (m_state == S_RUN && tick) begin
      m_run_tick = 1'b1;
      m_acc = m_acc + step_add(bus.sig);
      if (m_acc >= UNIT) begin
        m_acc = m_acc - UNIT;
        unit  = 1'b1;
      end
    end
    if (unit) begin
      if (m_total == MAXV) m_ovf = 1;
      m_total = (m_total + 1) % (MAXV + 1);
    end
    if (bus.trip_clr)               m_trip = 0;
    else if (unit && m_trip < MAXV) m_trip = m_trip + 1;
    if (tick) m_idx = (m_idx + 1) % DIGITS;
    if (bus.mode == 2'b00)                         m_state = S_IDLE;
    else if (m_state == S_IDLE && bus.mode == 2'b01) m_state = S_RUN;
    else if (m_state == S_RUN && bus.mode[1])        m_state = S_PAUSE;
    else if (m_state == S_PAUSE && bus.mode == 2'b01) m_state = S_RUN;
  endtask

  task automatic cycle();
    logic [DIGITS-1:0] exp_an;
    int shown, p;
    model_edge();
    @(posedge clk);
    #1;
    exp_an = '1;
    if (m_state != S_IDLE) exp_an[m_idx] = 1'b0;
    shown = bus.disp_sel ? m_trip : m_total;
    p = 1;
    for (int i = 0; i < m_idx; i++) p = p * 10;
    check("total",    32'(bus.total_bcd), 32'(to_bcd(m_total)));
    check("trip",     32'(bus.trip_bcd),  32'(to_bcd(m_trip)));
    check("active",   32'(bus.active),    32'(m_state == S_RUN));
    check("overflow", 32'(bus.overflow),  32'(m_ovf));
    check("scan_an",  32'(bus.scan_an),   32'(exp_an));
    check("scan_nib", 32'(bus.scan_nib),  32'((shown / p) % 10));
  endtask

  initial begin
    int g, ticks, saved;
    rst = 1'b1;
    bus.mode = 2'b00; bus.sig = 8'h00; bus.trip_clr = 1'b0; bus.disp_sel = 1'b0;

    // Reset values
    cycle(); cycle();
    check("rst_total",   32'(bus.total_bcd), 32'h0);
    check("rst_trip",    32'(bus.trip_bcd),  32'h0);
    check("rst_active",  32'(bus.active),    32'h0);
    check("rst_ovf",     32'(bus.overflow),  32'h0);
    check("rst_scan_an", 32'(bus.scan_an),   32'h3);

    // Run fast: three ticks give 2,4,6 -> one unit
    rst = 1'b0; bus.mode = 2'b01; bus.sig = 8'h01;
    cycle();
    check("active_after_run", 32'(bus.active), 32'h1);
    repeat (11) cycle();
    check("first_unit_total", 32'(bus.total_bcd), 32'h01);
    check("first_unit_trip",  32'(bus.trip_bcd),  32'h01);

    // Run to 99 then wrap the total; trip saturates
    g = 0;
    while (m_total != MAXV && g < 3000) begin cycle(); g++; end
    check("reach_99_total", 32'(bus.total_bcd), 32'h99);
    check("reach_99_ovf",   32'(bus.overflow),  32'h0);
    g = 0;
    while (m_total == MAXV && g < 200) begin cycle(); g++; end
    check("wrap_total", 32'(bus.total_bcd), 32'h00);
    check("wrap_ovf",   32'(bus.overflow),  32'h1);
    check("sat_trip",   32'(bus.trip_bcd),  32'h99);
    bus.disp_sel = 1'b1;
    repeat (40) cycle();
    check("ovf_sticky", 32'(bus.overflow), 32'h1);
    check("trip_held",  32'(bus.trip_bcd), 32'h99);
    bus.disp_sel = 1'b0;

    // Pause with remainder 1 for 20 ticks, then resume: unit after 2 ticks
    g = 0;
    while (m_acc != 1 && g < 100) begin cycle(); g++; end
    bus.mode = 2'b10;
    cycle();
    saved = m_total;
    repeat (80) cycle();
    check("pause_total", 32'(bus.total_bcd), 32'(to_bcd(saved)));
    bus.mode = 2'b01;
    ticks = 0; g = 0;
    while (m_total == saved && g < 100) begin
      cycle(); g++;
      if (m_run_tick) ticks++;
    end
    check("resume_ticks", 32'(ticks), 32'd2);
    check("resume_total", 32'(bus.total_bcd), 32'(to_bcd((saved + 1) % (MAXV + 1))));

    // trip_clr on the unit edge at 07
    rst = 1'b1; cycle(); rst = 1'b0;
    g = 0;
    while (m_total != 7 && g < 500) begin cycle(); g++; end
    check("pre_clr_trip", 32'(bus.trip_bcd), 32'h07);
    g = 0;
    while (!will_unit() && g < 100) begin cycle(); g++; end
    bus.trip_clr = 1'b1;
    cycle();
    bus.trip_clr = 1'b0;
    check("clr_total", 32'(bus.total_bcd), 32'h08);
    check("clr_trip",  32'(bus.trip_bcd),  32'h00);

    // Idle mid-run: blank display, counters held
    repeat (15) cycle();
    bus.mode = 2'b00;
    cycle();
    saved = m_total;
    check("idle_scan_an", 32'(bus.scan_an), 32'h3);
    repeat (20) cycle();
    check("idle_total_held", 32'(bus.total_bcd), 32'(to_bcd(saved)));
    bus.mode = 2'b01; bus.sig = 8'h02;
    repeat (30) cycle();

    // Reset mid-run
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_total",   32'(bus.total_bcd), 32'h0);
    check("mid_rst_trip",    32'(bus.trip_bcd),  32'h0);
    check("mid_rst_active",  32'(bus.active),    32'h0);
    check("mid_rst_ovf",     32'(bus.overflow),  32'h0);
    check("mid_rst_scan_an", 32'(bus.scan_an),   32'h3);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      bus.mode = 2'b00;
      else if (r < 8)  bus.mode = 2'b01;
      else             bus.mode = 2'($urandom_range(2, 3));
      if ($urandom_range(0, 7) == 0) bus.sig = 8'($urandom);
      bus.trip_clr = ($urandom_range(0, 63) == 0);
      bus.disp_sel = 1'($urandom);
      rst = ($urandom_range(0, 1499) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
